// File: rtl/spi_slave_rx.sv
// SPI slave receiver: LSB-first DATA_W-bit frames, oversampled in the clk domain.
// Define SPI_SLV_SYNC_EN for 2-flop input synchronizers; otherwise one register stage per input.
module spi_slave_rx #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] WAIT_CS = 2'd3;

  logic              sclk_s, cs_s, mosi_s, ready_s, rise_s;
  logic              sclk_prev_r;
  logic [1:0]        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [DATA_W-1:0] shift_r, shift_nxt_s, bit_s;
  logic [DATA_W-1:0] dout_r, dout_nxt_s;
  logic              done_r, done_nxt_s, err_r, err_nxt_s;

  // ready_s marks that the input stage holds real samples rather than reset values,
  // so a cs line still low across reset is not mistaken for a fresh frame start.
`ifdef SPI_SLV_SYNC_EN
  logic [1:0] sclk_q_r, cs_q_r, mosi_q_r, primed_r;

  // Two-flop synchronizers for the master-domain inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q_r <= 2'b00;
      cs_q_r   <= 2'b11;
      mosi_q_r <= 2'b00;
      primed_r <= 2'b00;
    end else begin
      sclk_q_r <= {sclk_q_r[0], sclk};
      cs_q_r   <= {cs_q_r[0], cs};
      mosi_q_r <= {mosi_q_r[0], mosi};
      primed_r <= {primed_r[0], 1'b1};
    end
  end

  assign sclk_s  = sclk_q_r[1];
  assign cs_s    = cs_q_r[1];
  assign mosi_s  = mosi_q_r[1];
  assign ready_s = primed_r[1];
`else
  logic sclk_q_r, cs_q_r, mosi_q_r, primed_r;

  // Single register stage for the master-domain inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q_r <= 1'b0;
      cs_q_r   <= 1'b1;
      mosi_q_r <= 1'b0;
      primed_r <= 1'b0;
    end else begin
      sclk_q_r <= sclk;
      cs_q_r   <= cs;
      mosi_q_r <= mosi;
      primed_r <= 1'b1;
    end
  end

  assign sclk_s  = sclk_q_r;
  assign cs_s    = cs_q_r;
  assign mosi_s  = mosi_q_r;
  assign ready_s = primed_r;
`endif

  assign rise_s = sclk_s & ~sclk_prev_r;
  assign bit_s  = {{(DATA_W-1){1'b0}}, mosi_s} << cnt_r;

  // Next-state and output decode for the frame FSM
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shift_nxt_s = shift_r;
    dout_nxt_s  = dout_r;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!cs_s) begin
          state_nxt_s = SHIFT;
          cnt_nxt_s   = {CNT_W{1'b0}};
          shift_nxt_s = {DATA_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (rise_s) begin
          shift_nxt_s = shift_r | bit_s;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end else begin
          shift_nxt_s = shift_r;
        end
        // The final edge wins over a simultaneous cs release.
        if (rise_s && (cnt_r == LAST_BIT)) begin
          state_nxt_s = HOLD;
        end else if (cs_s) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      HOLD: begin
        dout_nxt_s  = shift_r;
        done_nxt_s  = 1'b1;
        state_nxt_s = WAIT_CS;
      end
      WAIT_CS: begin
        if (cs_s && ready_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_CS;
        end
      end
      default: begin
        state_nxt_s = WAIT_CS;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= WAIT_CS;
      cnt_r       <= {CNT_W{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      dout_r      <= {DATA_W{1'b0}};
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      sclk_prev_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      dout_r      <= dout_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
      sclk_prev_r <= sclk_s;
    end
  end

  assign dout = dout_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx; build with or without SPI_SLV_SYNC_EN.
module tb_spi_slave_rx;

  localparam int DATA_W = 12;
`ifdef SPI_SLV_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic              clk = 1'b0;
  logic              rst, sclk, cs, mosi;
  logic [DATA_W-1:0] dout;
  logic              done, err;

  typedef struct packed {
    logic              is_err;
    logic [DATA_W-1:0] dout;
  } ev_t;

  ev_t               sb_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                cycle_cnt = 0;
  int                last_rise_cyc = 0;
  logic [DATA_W-1:0] exp_dout;

  spi_slave_rx #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pops one expected event per done/err pulse and checks kind, word and latency.
  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (done || err)) begin
        if (done && err) chk("done_err_overlap", 32'(done & err), 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_event", {30'd0, done, err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("event_kind_is_err", 32'(err), 32'(e.is_err));
          chk("event_dout", 32'(dout), 32'(e.dout));
          if (done) chk("done_latency", 32'(cycle_cnt - last_rise_cyc), 32'(LAT));
        end
      end
    end
  endtask

  // Drives nbits LSB-first; cs_last releases cs with the final rising edge,
  // keep_low leaves cs low at the end.
  task automatic send(input logic [31:0] w, input int nbits, input bit cs_last,
                      input bit keep_low);
    cs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[i];
      wait_clk(5);
      sclk = 1'b1;
      if (i == DATA_W - 1) last_rise_cyc = cycle_cnt;
      if (cs_last && (i == nbits - 1)) cs = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
    if (!keep_low) begin
      wait_clk(6);
      cs = 1'b1;
      wait_clk(12);
    end
  endtask

  task automatic push(input logic is_err, input logic [DATA_W-1:0] d);
    ev_t e;
    e.is_err = is_err;
    e.dout   = d;
    sb_q.push_back(e);
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    cs   = 1'b1;
    mosi = 1'b0;
    exp_dout = 12'h000;
    fork
      monitor();
    join_none
    wait_clk(5);
    rst = 1'b0;
    wait_clk(3);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Full frame
    exp_dout = 12'hA5C; push(1'b0, exp_dout);
    send(32'h0000_0A5C, 12, 1'b0, 1'b0);

    // Abort after 7 bits: err, dout keeps previous word
    push(1'b1, exp_dout);
    send(32'h0000_0FFF, 7, 1'b0, 1'b0);
    chk("abort_dout_kept", 32'(dout), 32'h0000_0A5C);

    // Back-to-back frames with a 2-sclk-period gap
    exp_dout = 12'h001; push(1'b0, exp_dout);
    send(32'h0000_0001, 12, 1'b0, 1'b0);
    wait_clk(8);
    exp_dout = 12'h800; push(1'b0, exp_dout);
    send(32'h0000_0800, 12, 1'b0, 1'b0);

    // 14 edges in one window: extra bits (ones) ignored
    exp_dout = 12'h3C3; push(1'b0, exp_dout);
    send(32'h0000_33C3, 14, 1'b0, 1'b0);

    // cs release coincides with the final rising edge
    exp_dout = 12'h6A9; push(1'b0, exp_dout);
    send(32'h0000_06A9, 12, 1'b1, 1'b0);

    // Reset after bit 5 with cs held low, then 7 more edges: silent discard
    send(32'h0000_0FFF, 5, 1'b0, 1'b1);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    exp_dout = 12'h000;
    send(32'h0000_0FFF, 7, 1'b0, 1'b0);
    chk("post_reset_dout", 32'(dout), 32'd0);
    exp_dout = 12'h155; push(1'b0, exp_dout);
    send(32'h0000_0155, 12, 1'b0, 1'b0);

    wait_clk(20);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("final_dout", 32'(dout), 32'h0000_0155);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter: DATA_W, 12, frame length in bits; legal range 2..32.
REQ-002 Port: clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: sclk  input  1  serial clock from the SPI master; asynchronous to clk, period >= 8 clk periods, high and low phases >= 4 clk periods each.
REQ-005 Port: cs  input  1  chip select from the master, active-low.
REQ-006 Port: mosi  input  1  serial data from the master, LSB first.
REQ-007 Port: dout  output  DATA_W  last complete received word.
REQ-008 Port: done  output  1  one-clk pulse when dout is updated with a new word.
REQ-009 Port: err  output  1  one-clk pulse when a frame is aborted early.

Function
REQ-010 sclk, cs and mosi SHALL be sampled in the clk domain through the input stage defined under Configuration; the stage outputs are sclk_s, cs_s and mosi_s.
REQ-011 A rising sclk edge SHALL be detected as sclk_s=1 while the registered previous sclk_s=0; mosi_s SHALL be captured on the same clk cycle.
REQ-012 FSM states: IDLE, SHIFT, HOLD, WAIT_CS.
REQ-013 IDLE: on cs_s=0, go to SHIFT and clear the bit counter and shift register.
REQ-014 SHIFT: each detected rising edge SHALL insert mosi_s at bit index = counter (LSB first) and increment the counter (width ceil(log2(DATA_W+1))).
REQ-015 SHIFT: when the DATA_W-th bit is captured, go to HOLD; on the next clk, dout SHALL load the shift register and done SHALL pulse for exactly 1 clk.
REQ-016 HOLD: unconditionally go to WAIT_CS after 1 clk.
REQ-017 WAIT_CS: ignore all further sclk edges; on cs_s=1, go to IDLE.
REQ-018 SHIFT with cs_s=1 before DATA_W bits: err SHALL pulse for 1 clk, dout SHALL be unchanged, no done, go to IDLE.
REQ-019 A cs_s rise and the final rising edge in the same clk cycle SHALL count as a complete frame: done, no err.
REQ-020 done and err SHALL never be asserted in the same cycle.
REQ-021 A new frame SHALL start only from IDLE, so each cs-low period yields at most one word.
REQ-022 Latency: done SHALL assert exactly 2 clk after the cycle in which the final sclk_s rising edge is detected.

Reset
REQ-023 rst=1 SHALL set dout=0, done=0, err=0, counter=0, shift register=0, previous sclk_s=0, and all synchronizer flops to sclk=0, cs=1, mosi=0.
REQ-024 After reset, the FSM SHALL enter WAIT_CS, so a frame in progress when reset is released is discarded until cs_s=1 is seen.
REQ-025 Reset mid-frame SHALL abort the frame without any done or err pulse.

Configuration
REQ-026 Macro SPI_SLV_SYNC_EN defined: sclk, cs and mosi SHALL each pass through a 2-flop synchronizer before the edge detector; the REQ-022 latency is measured from the synchronizer outputs.
REQ-027 Macro SPI_SLV_SYNC_EN undefined: sclk, cs and mosi SHALL each pass through a single register stage; all other behaviour is identical.

Verification
REQ-028 Frame 12'hA5C sent LSB first, cs low for 12 sclk cycles then high -> dout=12'hA5C, one done pulse, err=0 throughout.
REQ-029 cs raised after 7 bits of 12'hFFF, previous dout=12'hA5C -> err pulses once, dout stays 12'hA5C, no done.
REQ-030 Back-to-back frames 12'h001 then 12'h800 with cs high for 2 sclk periods between them -> two done pulses; dout=12'h001, then dout=12'h800.
REQ-031 14 sclk cycles in one cs-low window carrying 12'h3C3 in the first 12 bits -> dout=12'h3C3, exactly one done, extra edges ignored.
REQ-032 rst pulsed after bit 5, cs held low, with 7 more sclk cycles -> dout=0, no done, no err; the next full frame 12'h155 after cs goes high then low -> dout=12'h155.
REQ-033 Run REQ-028..REQ-032 with SPI_SLV_SYNC_EN both defined and undefined; done timing SHALL match REQ-022 in each build.
